// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//
// Sequencing controller for the iterative multiply/divide datapath.
// A one-cycle multiply or divide request produces one load strobe, then
// exactly WIDTH step strobes tagged with an iteration index, then a one-cycle
// result-ready pulse. A request seen in the ready cycle starts the next
// operation back-to-back.
//
// Optional feature macro: MULTDIV_DIV0_EN
//   defined   : divisor_zero is sampled in LOAD; a divide by zero skips RUN
//               and flags data_exception in DONE.
//   undefined : divisor_zero is ignored, every operation runs WIDTH steps
//               and data_exception is constant 0.
//
// Parameters
//   WIDTH  datapath iterations per operation (power of two, >= 2)
//   CW     iteration index width, log2(WIDTH)
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset           synchronous active-high reset
//   ctrl_MULT       multiply request (priority over ctrl_DIV)
//   ctrl_DIV        divide request
//   divisor_zero    datapath flag, valid during LOAD: divisor is zero
//   dp_load         load operands (LOAD state)
//   dp_step         one shift/add or shift/subtract iteration (RUN state)
//   dp_op           0 = multiply, 1 = divide, held from LOAD through DONE
//   iter            current iteration index
//   busy            operation in progress (LOAD, RUN, DONE)
//   data_resultRDY  one-cycle pulse, result valid (DONE state)
//   data_exception  divide by zero, valid only with data_resultRDY
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ctrl_MULT,
   input  logic          ctrl_DIV,
   input  logic          divisor_zero,
   output logic          dp_load,
   output logic          dp_step,
   output logic          dp_op,
   output logic [CW-1:0] iter,
   output logic          busy,
   output logic          data_resultRDY,
   output logic          data_exception
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

   state_t        state_reg, state_next;
   logic          op_reg, op_next;
   logic          exc_reg, exc_next;
   logic [CW-1:0] iter_reg, iter_next;

   logic          req;

   // A request is only acted on in IDLE or DONE; elsewhere it is dropped.
   assign req = ctrl_MULT | ctrl_DIV;

`ifndef MULTDIV_DIV0_EN
   // Flag is not consumed when the short-circuit is compiled out.
   logic unused_divisor_zero;
   assign unused_divisor_zero = divisor_zero;
`endif

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         op_reg    <= 1'b0;
         exc_reg   <= 1'b0;
         iter_reg  <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         exc_reg   <= exc_next;
         iter_reg  <= iter_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      exc_next   = exc_reg;
      iter_next  = iter_reg;

      unique case (state_reg)
         IDLE: begin
            iter_next = '0;
            exc_next  = 1'b0;
            if (req) begin
               state_next = LOAD;
               // Multiply wins when both requests arrive together.
               op_next    = ~ctrl_MULT;
            end
         end

         LOAD: begin
            iter_next  = '0;
            state_next = RUN;
`ifdef MULTDIV_DIV0_EN
            if (op_reg && divisor_zero) begin
               exc_next   = 1'b1;
               state_next = DONE;
            end
`endif
         end

         RUN: begin
            if (iter_reg == ITER_LAST) begin
               iter_next  = '0;
               state_next = DONE;
            end else begin
               iter_next = iter_reg + 1'b1;
            end
         end

         DONE: begin
            iter_next = '0;
            exc_next  = 1'b0;
            if (req) begin
               // Back-to-back: reload op and go straight to LOAD.
               state_next = LOAD;
               op_next    = ~ctrl_MULT;
            end else begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            op_next    = 1'b0;
            exc_next   = 1'b0;
            iter_next  = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Moore outputs, decoded from registered state only
   // ---------------------------------------------------------------------
   always_comb begin
      dp_load        = 1'b0;
      dp_step        = 1'b0;
      dp_op          = 1'b0;
      busy           = 1'b0;
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      iter           = iter_reg;

      unique case (state_reg)
         IDLE: begin
            // op_reg may still hold the last operation; keep dp_op quiet.
         end
         LOAD: begin
            dp_load = 1'b1;
            dp_op   = op_reg;
            busy    = 1'b1;
         end
         RUN: begin
            dp_step = 1'b1;
            dp_op   = op_reg;
            busy    = 1'b1;
         end
         DONE: begin
            data_resultRDY = 1'b1;
            data_exception = exc_reg;
            dp_op          = op_reg;
            busy           = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
//
// Directed bench for multdiv_ctrl (WIDTH = 32). Each scenario resets the
// design for cycles 0-1, then walks cycle by cycle, driving requests and
// comparing the packed output vector against the hand-derived timeline:
//   request in T -> LOAD T+1, RUN T+2..T+33 (iter 0..31), DONE T+34.
// Cycle c is the interval after the c-th rising edge; inputs are driven and
// outputs sampled 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;

   localparam int WIDTH = 32;
   localparam int CW    = 5;
   localparam int VW    = 6 + CW;

`ifdef MULTDIV_DIV0_EN
   localparam bit DIV0_ON = 1'b1;
`else
   localparam bit DIV0_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          ctrl_MULT;
   logic          ctrl_DIV;
   logic          divisor_zero;
   logic          dp_load;
   logic          dp_step;
   logic          dp_op;
   logic [CW-1:0] iter;
   logic          busy;
   logic          data_resultRDY;
   logic          data_exception;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   multdiv_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .divisor_zero   (divisor_zero),
      .dp_load        (dp_load),
      .dp_step        (dp_step),
      .dp_op          (dp_op),
      .iter           (iter),
      .busy           (busy),
      .data_resultRDY (data_resultRDY),
      .data_exception (data_exception)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Expected {load,step,rdy,exc,busy,op,iter} for one operation requested in t0.
   function automatic logic [VW-1:0] op_vec(input int c, input int t0, input bit op, input bit skip);
      logic [VW-1:0] v;
      v = '0;
      if (c == t0 + 1)
         v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, op, CW'(0)};
      else if (skip && c == t0 + 2)
         v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, op, CW'(0)};
      else if (!skip && c >= t0 + 2 && c <= t0 + WIDTH + 1)
         v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, op, CW'(c - t0 - 2)};
      else if (!skip && c == t0 + WIDTH + 2)
         v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, op, CW'(0)};
      return v;
   endfunction

   task automatic run_scenario(input int id, input string name, input int last, input int exp_rdy);
      logic [VW-1:0] got, exp;
      int rdy_cnt;
      int fail_before;
      rdy_cnt     = 0;
      fail_before = failures;
      cyc          = 0;
      reset        = 1'b1;
      ctrl_MULT    = 1'b0;
      ctrl_DIV     = 1'b0;
      divisor_zero = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      // Cycle 2: reset has been sampled, all outputs must be zero.
      got = {dp_load, dp_step, data_resultRDY, data_exception, busy, dp_op, iter};
      check($sformatf("%s reset_state", name), 32'(got), 32'(0));
      while (cyc <= last) begin
         ctrl_MULT    = 1'b0;
         ctrl_DIV     = 1'b0;
         divisor_zero = 1'b0;
         reset        = 1'b0;
         exp          = '0;
         case (id)
            2: begin
               ctrl_MULT = (cyc == 5);
               exp = op_vec(cyc, 5, 1'b0, 1'b0);
            end
            3: begin
               ctrl_DIV     = (cyc == 5);
               divisor_zero = (cyc == 6);
               exp = op_vec(cyc, 5, 1'b1, DIV0_ON);
            end
            4: begin
               ctrl_MULT = (cyc == 5);
               ctrl_DIV  = (cyc == 5) || (cyc == 20);
               exp = op_vec(cyc, 5, 1'b0, 1'b0);
            end
            5: begin
               ctrl_MULT = (cyc == 5);
               ctrl_DIV  = (cyc == 39);
               exp = op_vec(cyc, 5, 1'b0, 1'b0) | op_vec(cyc, 39, 1'b1, 1'b0);
            end
            6: begin
               ctrl_MULT = (cyc == 5) || (cyc == 17);
               reset     = (cyc == 15);
               exp = (cyc <= 15) ? op_vec(cyc, 5, 1'b0, 1'b0) : op_vec(cyc, 17, 1'b0, 1'b0);
            end
            default: exp = '0;
         endcase
         got = {dp_load, dp_step, data_resultRDY, data_exception, busy, dp_op, iter};
         if (data_resultRDY) rdy_cnt++;
         check($sformatf("%s cyc%0d", name, cyc), 32'(got), 32'(exp));
         tick();
      end
      check($sformatf("%s rdy_pulses", name), 32'(rdy_cnt), 32'(exp_rdy));
      $display("scenario %-10s cycles=%0d rdy_pulses=%0d errors=%0d",
               name, last, rdy_cnt, failures - fail_before);
   endtask

   initial begin
      reset        = 1'b1;
      ctrl_MULT    = 1'b0;
      ctrl_DIV     = 1'b0;
      divisor_zero = 1'b0;
      run_scenario(1, "idle",      11, 0);
      run_scenario(2, "multiply",  45, 1);
      run_scenario(3, "div_zero",  45, 1);
      run_scenario(4, "both_req",  45, 1);
      run_scenario(5, "back2back", 80, 2);
      run_scenario(6, "mid_reset", 58, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the iterative multiply/divide datapath in `multdiv`. It accepts a one-cycle multiply or divide request and issues a single load strobe, followed by exactly WIDTH step strobes, each tagged with an iteration index. It then reports completion with a one-cycle ready pulse. Divide-by-zero short-circuit is compiled in or out. It replaces the free-running iteration counter with an explicit request/done handshake for the processor stall logic.

## Interface
- WIDTH, 32, number of datapath iterations per operation; power of two, at least 2.
- CW, 5, width of the iteration index; equals log2(WIDTH).

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_MULT  input  1  multiply request, sampled on the rising edge.
- ctrl_DIV  input  1  divide request, sampled on the rising edge.
- divisor_zero  input  1  from datapath, valid during LOAD: divisor operand is 0.
- dp_load  output  1  load operands into the datapath registers.
- dp_step  output  1  perform one shift/add or shift/subtract iteration.
- dp_op  output  1  0 = multiply, 1 = divide; held from LOAD through DONE.
- iter  output  CW  current iteration index.
- busy  output  1  operation in progress.
- data_resultRDY  output  1  one-cycle pulse: result valid at the datapath output.
- data_exception  output  1  valid only with data_resultRDY: divide by zero.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Outputs are Moore outputs, decoded from the registered state, op, exc and iter.
- IDLE: all strobes are 0 and busy is 0.
  - Request sampled: next state LOAD.
  - ctrl_MULT has priority when both requests are high (op = 0). Otherwise ctrl_DIV sets op = 1.
- LOAD: dp_load = 1, busy = 1, iter = 0.
  - Next state RUN.
  - With MULTDIV_DIV0_EN: if op = 1 and divisor_zero = 1, set exc = 1 and go to DONE.
- RUN: dp_step = 1, busy = 1.
  - iter increments by 1 each cycle, 0 through WIDTH-1.
  - At iter = WIDTH-1, iter wraps to 0 and the next state is DONE.
- DONE: data_resultRDY = 1, data_exception = exc, busy = 1, iter = 0.
  - A request sampled in DONE is accepted: next state LOAD, op/exc reloaded, back-to-back operation.
  - Otherwise the next state is IDLE and exc clears.
- Requests sampled in LOAD or RUN are ignored. They are not queued.
- dp_load, dp_step and data_resultRDY are mutually exclusive. Each is high only in its own state.

## Timing
- Reset, checked before all other conditions on the edge:
  - The next cycle is IDLE.
  - iter = 0, op = 0, exc = 0.
  - All outputs are 0.
- Reset mid-operation aborts the operation. No data_resultRDY is generated for it.
- Request high in cycle T:
  - LOAD in T+1.
  - RUN in T+2 through T+WIDTH+1; dp_step asserts exactly WIDTH times.
  - DONE in T+WIDTH+2. For WIDTH = 32, resultRDY falls in T+34.
- Divide-by-zero (macro on): LOAD in T+1, DONE in T+2 with data_exception = 1, and zero dp_step pulses.
- Back-to-back: request in the DONE cycle gives LOAD in the next cycle. Throughput is one operation per WIDTH+2 cycles.
- busy goes high in T+1 and falls in the cycle after DONE, unless a new operation starts.
- dp_op is stable from T+1 through the DONE cycle.

## Configuration
- MULTDIV_DIV0_EN defined:
  - divisor_zero is sampled in LOAD.
  - A zero divisor skips RUN and flags data_exception in DONE.
- MULTDIV_DIV0_EN undefined:
  - divisor_zero is ignored.
  - Every divide runs the full WIDTH iterations.
  - exc is never set; data_exception is constant 0.
  - The DONE timing of every divide is identical to a multiply.

## Test plan
- Reset then idle, WIDTH = 32:
  - Hold reset 2 cycles, then release with no request.
  - Required: all outputs 0 and iter = 0 for 10 cycles.
- Multiply request:
  - ctrl_MULT high in cycle 5.
  - Required: dp_load in cycle 6; dp_step with iter 0..31 in cycles 7–38; data_resultRDY = 1 with data_exception = 0 in cycle 39 only; busy = 0 in cycle 40.
- Divide by zero, macro on:
  - ctrl_DIV high in cycle 5, divisor_zero = 1 in cycle 6.
  - Required: DONE in cycle 7 with data_exception = 1; no dp_step pulses.
  - With the macro off, the same stimulus must give DONE in cycle 39 with data_exception = 0.
- Simultaneous and ignored requests:
  - ctrl_MULT and ctrl_DIV both high in cycle 5.
  - Required: dp_op = 0 for the whole operation.
  - Then pulse ctrl_DIV during RUN (cycle 20). Required: no effect, and exactly one resultRDY pulse, in cycle 39.
- Back-to-back:
  - ctrl_DIV high in the DONE cycle 39 of a multiply.
  - Required: LOAD in cycle 40 with dp_op = 1; resultRDY in cycle 73; busy never drops between the two operations.
- Reset mid-operation:
  - Assert reset in cycle 15 of a multiply started in cycle 5.
  - Required: IDLE in cycle 16 with all outputs 0; no data_resultRDY ever.
  - A new ctrl_MULT in cycle 17 must complete normally in cycle 51.
